game_scheduler: RTL and testbench

Top-level run controller for the dino game datapath. It turns the display frame tick into the `update`/`timer` strobes consumed by the horizon and obstacle logic. It owns the game speed ramp, the obstacle-free clear period and the start/crash/restart sequence. It is the only block that drives `start`, `crash`, `speed`, `has_obstacles` and the datapath soft reset.

---
 rtl/game_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_game_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_scheduler.sv
// game_scheduler
//   Run controller for the dino game datapath. Converts the display frame tick
//   into update/timer strobes, owns the speed ramp, the obstacle-free clear
//   period and the start / crash / restart sequence.
//
//   Optional feature macro: GAME_SCHED_ACCEL_EN
//     defined   : speed ramps by ACCEL per update, clamped at MAX_SPEED
//     undefined : speed stays at INIT_SPEED for the whole run
//
//   Ports
//     clk            in   clock
//     rst            in   synchronous, active-high reset
//     frame_tick     in   one-cycle pulse per display frame
//     jump_btn       in   synchronized button level
//     collision      in   level from collision detector
//     update         out  one-cycle frame strobe to datapath
//     timer[5:0]     out  ms since previous update (saturating at 63)
//     start          out  one-cycle run-start pulse
//     crash          out  high throughout CRASHED
//     speed[14:0]    out  current speed x1024
//     has_obstacles  out  obstacle generation enable
//     game_rst       out  one-cycle datapath soft reset
//     state_o[2:0]   out  FSM state encoding (debug)
module game_scheduler #(
  parameter int CLK_PER_MS       = 25000,
  parameter int INIT_SPEED       = 6144,
  parameter int MAX_SPEED        = 13312,
  parameter int ACCEL            = 1,
  parameter int CLEAR_FRAMES     = 180,
  parameter int RESTART_DELAY_MS = 750
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        jump_btn,
  input  logic        collision,
  output logic        update,
  output logic [5:0]  timer,
  output logic        start,
  output logic        crash,
  output logic [14:0] speed,
  output logic        has_obstacles,
  output logic        game_rst,
  output logic [2:0]  state_o
);

  localparam int PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int FRM_W = $clog2(CLEAR_FRAMES + 1);
  localparam int CMS_W = $clog2(RESTART_DELAY_MS + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_MS - 1);
  localparam logic [FRM_W-1:0] FRM_SAT  = FRM_W'(CLEAR_FRAMES);
  localparam logic [CMS_W-1:0] CMS_SAT  = CMS_W'(RESTART_DELAY_MS);
  // The starting speed is clamped too, so speed can never exceed the ceiling.
  localparam logic [14:0]      SPD_INIT = (INIT_SPEED > MAX_SPEED) ? 15'(MAX_SPEED)
                                                                  : 15'(INIT_SPEED);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_STARTING = 3'd1,
    S_RUNNING  = 3'd2,
    S_CRASHED  = 3'd3,
    S_RESTART  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_jump_d;
  logic               r_rise;
  logic [PRE_W-1:0]   r_pre;
  logic [5:0]         r_acc;
  logic [1:0]         r_hold;
  logic [FRM_W-1:0]   r_frames;
  logic [CMS_W-1:0]   r_crash_ms;
  logic               r_update;
  logic [5:0]         r_timer;
  logic               r_start;
  logic               r_crash;
  logic [14:0]        r_speed;
  logic               r_has_obs;
  logic               r_game_rst;
  logic               w_ms_tick;
  logic               w_issue;

  assign w_ms_tick = (r_pre == PRE_LAST);

  // A frame is accepted only while running, outside hold-off, and never in
  // the same cycle as a collision (the crash takes priority).
  assign w_issue = (r_state == S_RUNNING) && frame_tick && !collision &&
                   (r_hold == 2'd0);

`ifdef GAME_SCHED_ACCEL_EN
  logic [15:0] w_spd_sum;
  logic [14:0] w_spd_next;
  assign w_spd_sum  = {1'b0, r_speed} + 16'(ACCEL);
  assign w_spd_next = (w_spd_sum > 16'(MAX_SPEED)) ? 15'(MAX_SPEED) : w_spd_sum[14:0];
`endif

  // Button edge is registered, so the FSM sees it one cycle after the rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_jump_d <= 1'b0;
      r_rise   <= 1'b0;
    end else begin
      r_jump_d <= jump_btn;
      r_rise   <= jump_btn & ~r_jump_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (r_rise) w_next = S_STARTING;
      S_STARTING: w_next = S_RUNNING;
      S_RUNNING:  if (collision) w_next = S_CRASHED;
      S_CRASHED:  if (r_rise && (r_crash_ms == CMS_SAT)) w_next = S_RESTART;
      S_RESTART:  w_next = S_STARTING;
      default:    w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so start,
  // crash and game_rst line up exactly with their states.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre      <= '0;
      r_acc      <= '0;
      r_hold     <= '0;
      r_frames   <= '0;
      r_crash_ms <= '0;
      r_update   <= 1'b0;
      r_timer    <= '0;
      r_start    <= 1'b0;
      r_crash    <= 1'b0;
      r_game_rst <= 1'b0;
      r_has_obs  <= 1'b0;
      r_speed    <= SPD_INIT;
    end else begin
      r_pre      <= w_ms_tick ? '0 : r_pre + PRE_W'(1);
      r_start    <= (w_next == S_STARTING);
      r_crash    <= (w_next == S_CRASHED);
      r_game_rst <= (w_next == S_RESTART);
      r_update   <= w_issue;

      // Hold-off: three cycles after the update strobe during which ticks drop.
      if (w_issue)              r_hold <= 2'd3;
      else if (r_hold != 2'd0)  r_hold <= r_hold - 2'd1;

      // Elapsed-ms accumulator; a coincident ms tick is counted for the next frame.
      if (w_issue) begin
        r_timer <= r_acc;
        r_acc   <= w_ms_tick ? 6'd1 : 6'd0;
      end else if (w_ms_tick && (r_acc != 6'd63)) begin
        r_acc   <= r_acc + 6'd1;
      end

      // Restart lockout counter, held at zero outside CRASHED.
      if (r_state != S_CRASHED)                       r_crash_ms <= '0;
      else if (w_ms_tick && (r_crash_ms != CMS_SAT))  r_crash_ms <= r_crash_ms + CMS_W'(1);

      // Clear period: obstacles enable together with the final clear update.
      if (w_next == S_STARTING) begin
        r_frames  <= '0;
        r_has_obs <= 1'b0;
      end else if (w_issue && (r_frames != FRM_SAT)) begin
        r_frames <= r_frames + FRM_W'(1);
        if (r_frames + FRM_W'(1) == FRM_SAT) r_has_obs <= 1'b1;
      end

      // Speed steps after the update strobe so the datapath samples the old value.
      if (w_next == S_STARTING) r_speed <= SPD_INIT;
`ifdef GAME_SCHED_ACCEL_EN
      else if (r_update)        r_speed <= w_spd_next;
`endif
    end
  end

  assign update        = r_update;
  assign timer         = r_timer;
  assign start         = r_start;
  assign crash         = r_crash;
  assign speed         = r_speed;
  assign has_obstacles = r_has_obs;
  assign game_rst      = r_game_rst;
  assign state_o       = r_state;

endmodule

// File: tb/tb_game_scheduler.sv
// Testbench for game_scheduler: randomized frame traffic against a
// behavioural model; expected strobes are queued by the stimulus side and
// consumed by an independent monitor.
module tb_game_scheduler;
  localparam int CPM  = 10;
  localparam int INIT = 6144;
  localparam int MAXS = 13312;
  localparam int ACC  = 1;
  localparam int CLR  = 180;
  localparam int RDLY = 750;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        jump_btn = 1'b0;
  logic        collision = 1'b0;
  logic        update, start, crash, has_obstacles, game_rst;
  logic [5:0]  timer;
  logic [14:0] speed;
  logic [2:0]  state_o;

  game_scheduler #(.CLK_PER_MS(CPM)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .jump_btn(jump_btn),
    .collision(collision), .update(update), .timer(timer), .start(start),
    .crash(crash), .speed(speed), .has_obstacles(has_obstacles),
    .game_rst(game_rst), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Cycle index since the last reset edge: equals the DUT's ms prescaler phase.
  int cyc = 0;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  typedef struct { int cyc; int tmr; int spd; int obst; } upd_t;
  upd_t q_upd[$];
  int   q_start[$];
  int   q_grst[$];

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  // Model state: phase 0 idle, 1 running, 2 crashed.
  int m_phase, m_n, m_last, m_tref, m_ecyc;

  function automatic int exp_speed(input int n);
`ifdef GAME_SCHED_ACCEL_EN
    int s;
    s = INIT + ACC * n;
    return (s > MAXS) ? MAXS : s;
`else
    return INIT + 0 * n;
`endif
  endfunction

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT strobes.
  always @(negedge clk) begin
    upd_t e;
    int   c;
    if (armed) begin
      if (update === 1'b1) begin
        chk("update_expected", int'(q_upd.size() > 0), 1);
        if (q_upd.size() > 0) begin
          e = q_upd.pop_front();
          chk("upd_cycle", cyc, e.cyc);
          chk("upd_timer", int'(timer), e.tmr);
          chk("upd_speed", int'(speed), e.spd);
          chk("upd_obst", int'(has_obstacles), e.obst);
        end
      end
      if (start === 1'b1) begin
        chk("start_expected", int'(q_start.size() > 0), 1);
        if (q_start.size() > 0) begin
          c = q_start.pop_front();
          chk("start_cycle", cyc, c);
          chk("start_speed", int'(speed), INIT);
          chk("start_obst", int'(has_obstacles), 0);
        end
      end
      if (game_rst === 1'b1) begin
        chk("grst_expected", int'(q_grst.size() > 0), 1);
        if (q_grst.size() > 0) begin
          c = q_grst.pop_front();
          chk("grst_cycle", cyc, c);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step();
    rst = 1'b0;
    m_phase = 0; m_n = 0; m_last = -100; m_tref = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"},  int'(state_o), 0);
    chk({tag, "_update"}, int'(update), 0);
    chk({tag, "_start"},  int'(start), 0);
    chk({tag, "_crash"},  int'(crash), 0);
    chk({tag, "_grst"},   int'(game_rst), 0);
    chk({tag, "_obst"},   int'(has_obstacles), 0);
    chk({tag, "_timer"},  int'(timer), 0);
    chk({tag, "_speed"},  int'(speed), INIT);
  endtask

  // One frame tick (optionally with collision) in the current cycle.
  task automatic tick(input bit col);
    int   k, t;
    upd_t e;
    k = cyc;
    frame_tick = 1'b1;
    collision  = col;
    if (m_phase == 1) begin
      if (col) begin
        m_phase = 2;
        m_ecyc  = k + 1;
      end else if (k >= m_last + 4) begin
        t = k / CPM - m_tref / CPM;
        if (t > 63) t = 63;
        e.cyc = k + 1; e.tmr = t; e.spd = exp_speed(m_n); e.obst = int'(m_n + 1 >= CLR);
        q_upd.push_back(e);
        m_n++; m_last = k; m_tref = k;
      end
    end
    step();
    frame_tick = 1'b0;
    collision  = 1'b0;
  endtask

  // One-cycle jump press; returns four cycles after the rise.
  task automatic press();
    int k;
    k = cyc;
    jump_btn = 1'b1;
    if (m_phase == 0) begin
      q_start.push_back(k + 2);
      m_phase = 1; m_n = 0;
    end else if (m_phase == 2 && ((k + 1) / CPM - m_ecyc / CPM) >= RDLY) begin
      q_grst.push_back(k + 2);
      q_start.push_back(k + 3);
      m_phase = 1; m_n = 0;
    end
    step();
    jump_btn = 1'b0;
    idle(3);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);
    armed = 1'b1;
    check_reset_vals("reset");
    idle(20);

    press();
    idle(2);
    tick(0);
    idle(1);
    chk("speed_after_first", int'(speed), exp_speed(1));

    idle(8);
    for (int i = 0; i < 4; i++) begin
      tick(0);
      chk("timer_1ms", int'(timer), 1);
      idle(9);
    end

    tick(0);
    idle(2);
    tick(0);
    chk("holdoff_drop", int'(update), 0);
    tick(0);

    idle(1000);
    tick(0);
    chk("timer_sat", int'(timer), 63);

    for (int it = 0; it < 3000 && m_n < CLR; it++) begin
      idle($urandom_range(0, 6));
      tick(0);
    end
    chk("obst_on_clear", int'(has_obstacles), 1);
    idle(1);
    chk("speed_after_clear", int'(speed), exp_speed(CLR));

    for (int it = 0; it < 8000 && m_n < 7300; it++) begin
      tick(0);
      idle(3);
    end
    chk("speed_saturated", int'(speed), exp_speed(m_n));

    idle(5);
    tick(1);
    chk("crash_level", int'(crash), 1);
    chk("crash_state", int'(state_o), 3);
    chk("no_update_on_crash", int'(update), 0);
    idle(3);
    tick(0);
    tick(0);
    idle(5);
    chk("speed_frozen", int'(speed), exp_speed(m_n));

    while (cyc < m_ecyc + 500 * CPM) step();
    press();
    chk("early_jump_state", int'(state_o), 3);
    chk("early_jump_crash", int'(crash), 1);

    while (cyc < m_ecyc + 800 * CPM) step();
    press();
    chk("restart_state", int'(state_o), 2);
    chk("restart_crash", int'(crash), 0);
    chk("restart_speed", int'(speed), INIT);
    chk("restart_obst", int'(has_obstacles), 0);

    for (int it = 0; it < 2000 && m_n < 856; it++) begin
      tick(0);
      idle(3);
    end
    idle(2);
    chk("speed_before_rst", int'(speed), exp_speed(856));
    do_reset(1);
    check_reset_vals("midrun_rst");

    idle(30);
    press();
    idle(2);
    tick(0);
    idle(6);
    tick(0);
    idle(20);

    chk("upd_leftover", q_upd.size(), 0);
    chk("start_leftover", q_start.size(), 0);
    chk("grst_leftover", q_grst.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
